// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several producers.
// The winner keeps the grant for a burst of up to BURST words.
module fifo_write_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BURST      = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [REQUESTERS-1:0]         i_request,
  input  logic [REQUESTERS*WIDTH-1:0]   i_wdata,
  output logic [REQUESTERS-1:0]         o_ack,
  output logic [REQUESTERS-1:0]         o_grant,
  output logic                          o_fifo_write,
  output logic [WIDTH-1:0]              o_fifo_wdata,
  input  logic                          i_fifo_full
);

  localparam int unsigned IdxW = $clog2(REQUESTERS);
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam logic [IdxW-1:0] LastReset = IdxW'(REQUESTERS - 1);
  localparam logic [CntW-1:0] CountLast = CntW'(BURST - 1);

  typedef enum logic {StIdle, StGranted} state_e;

  state_e                r_state;
  logic [REQUESTERS-1:0] r_grant;
  logic [IdxW-1:0]       r_owner;
  logic [IdxW-1:0]       r_last;
  logic [CntW-1:0]       r_count;

  logic [IdxW-1:0]       w_winner;
  logic [IdxW-1:0]       w_cand;
  logic [REQUESTERS-1:0] w_onehot;
  logic                  w_any;
  logic                  w_write;
  int unsigned           w_idx;

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    w_winner = r_last;
    w_any    = 1'b0;
    w_idx    = 0;
    w_cand   = '0;
    for (int unsigned i = 1; i <= REQUESTERS; i++) begin
      w_idx  = (32'(r_last) + i) % REQUESTERS;
      w_cand = IdxW'(w_idx);
      if (!w_any && i_request[w_cand]) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  // Reset suppresses the strobe so nothing is written in the reset cycle.
  assign w_write      = (r_state == StGranted) & i_request[r_owner] & ~i_fifo_full & ~i_reset;
  assign o_fifo_write = w_write;
  assign o_ack        = w_write ? r_grant : '0;
  assign o_grant      = r_grant;
  assign o_fifo_wdata = i_wdata[r_owner*WIDTH +: WIDTH];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= LastReset;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state <= StGranted;
            r_grant <= w_onehot;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_count <= '0;
          end
        end
        StGranted: begin
          if (!i_request[r_owner]) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_count <= '0;
          end else if (!i_fifo_full) begin
            if (r_count == CountLast) begin
              r_state <= StIdle;
              r_grant <= '0;
              r_count <= '0;
            end else begin
              r_count <= r_count + CntW'(1);
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
